// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition writer: FSM state encoding and
// the decimation control width.
package acq_pkg;

    localparam int DECIMW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_CAPTURE,
        ST_DONE
    } acq_state_e;

endpackage

// File: rtl/acq_writer.sv
// Trigger-delayed, decimated ADC capture into an external sample RAM; after
// capture it holds done and lends the RAM address port to the host.
module acq_writer
    import acq_pkg::*;
#(
    parameter int DATASIZE  = 12,
    parameter int ADDRSIZE  = 7,
    parameter int DELAYSIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig,
    input  logic [DELAYSIZE-1:0] delay,
    input  logic [ADDRSIZE:0]    nsamples,
    input  logic [DECIMW-1:0]    decim,
    input  logic                 adc_valid,
    input  logic [DATASIZE-1:0]  adc_data,
    input  logic                 ack,
    input  logic [ADDRSIZE-1:0]  rd_addr,
    output logic [DATASIZE-1:0]  rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 trig_ignored,
    output logic                 ram_enw,
    output logic [ADDRSIZE-1:0]  ram_addr,
    output logic [DATASIZE-1:0]  ram_datai,
    input  logic [DATASIZE-1:0]  ram_datao
);

    localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

    acq_state_e           state_q,   state_d;
    logic [DELAYSIZE-1:0] delay_q,   delay_d;
    logic [DELAYSIZE-1:0] dcnt_q,    dcnt_d;
    logic [ADDRSIZE:0]    nsamp_q,   nsamp_d;
    logic [DECIMW-1:0]    decim_q,   decim_d;
    logic [DECIMW-1:0]    phase_q,   phase_d;
    logic [ADDRSIZE:0]    cnt_q,     cnt_d;
    logic [ADDRSIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [DATASIZE-1:0]  datai_q,   datai_d;
    logic                 enw_q,     enw_d;
    logic                 ign_q,     ign_d;
    logic                 start;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        dcnt_d    = dcnt_q;
        nsamp_d   = nsamp_q;
        decim_d   = decim_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        datai_d   = datai_q;
        enw_d     = 1'b0;
        ign_d     = 1'b0;
        start     = 1'b0;

        case (state_q)
            ST_IDLE: start = trig;
            ST_DELAY: begin
                ign_d = trig;
                // dcnt starts at 1 on trig, so the DELAY state lasts max(delay,1) cycles
                if (dcnt_q >= delay_q) begin
                    state_d = (nsamp_q == '0) ? ST_DONE : ST_CAPTURE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                ign_d = trig;
                if (adc_valid) begin
                    phase_d = (phase_q == decim_q) ? '0 : phase_q + 1'b1;
                    if (phase_q == '0) begin
                        enw_d     = 1'b1;
                        datai_d   = adc_data;
                        wr_addr_d = cnt_q[ADDRSIZE-1:0];
                        cnt_d     = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == nsamp_q) state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (trig)     start   = 1'b1;
                else if (ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d = ST_DELAY;
            delay_d = delay;
            dcnt_d  = {{(DELAYSIZE-1){1'b0}}, 1'b1};
            nsamp_d = (nsamples > DEPTH) ? DEPTH : nsamples;
            decim_d = decim;
            phase_d = '0;
            cnt_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            delay_q   <= '0;
            dcnt_q    <= '0;
            nsamp_q   <= '0;
            decim_q   <= '0;
            phase_q   <= '0;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            datai_q   <= '0;
            enw_q     <= 1'b0;
            ign_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            dcnt_q    <= dcnt_d;
            nsamp_q   <= nsamp_d;
            decim_q   <= decim_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            datai_q   <= datai_d;
            enw_q     <= enw_d;
            ign_q     <= ign_d;
        end
    end

    // The write port owns the address only while a write is in flight
    assign ram_addr     = enw_q ? wr_addr_q : rd_addr;
    assign ram_enw      = enw_q;
    assign ram_datai    = datai_q;
    assign rd_data      = ram_datao;
    assign busy         = (state_q == ST_DELAY) || (state_q == ST_CAPTURE);
    assign done         = (state_q == ST_DONE);
    assign trig_ignored = ign_q;

endmodule
